// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - fetch port, data port and memory_controller bus of memory_arbiter
// master modport is the arbiter's view; slave is the surrounding core/memory view.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [3:0]        i_prot;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              i_abort;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_write;
    logic [1:0]        d_size;
    logic [3:0]        d_prot;
    logic              d_lock;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_abort;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic [1:0]        size;
    logic [3:0]        prot;
    logic [1:0]        trans;
    logic [DATA_W-1:0] rdata;
    logic              abort;
    logic              mem_wait;

    modport master (
        input  i_req, i_addr, i_prot,
        output i_done, i_rdata, i_abort,
        input  d_req, d_addr, d_wdata, d_write, d_size, d_prot, d_lock,
        output d_done, d_rdata, d_abort,
        output addr, wdata, write, size, prot, trans,
        input  rdata, abort, mem_wait
    );

    modport slave (
        output i_req, i_addr, i_prot,
        input  i_done, i_rdata, i_abort,
        output d_req, d_addr, d_wdata, d_write, d_size, d_prot, d_lock,
        input  d_done, d_rdata, d_abort,
        input  addr, wdata, write, size, prot, trans,
        output rdata, abort, mem_wait
    );
endinterface

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares the memory_controller bus between fetch and data ports
// Define MEMORY_ARBITER_ROUND_ROBIN_EN to alternate grants on contention instead of data-first priority.
module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    memory_arbiter_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;

    state_t state, state_next;
    owner_t owner, owner_next;
    logic   grant_fetch;
    logic   grant_data;
    logic   complete;
    logic   prefer_data;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic last_fetch;

    // Locked continuations go through grant_data, so they count as data grants.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_fetch <= 1'b1;
        end else if (grant_fetch) begin
            last_fetch <= 1'b1;
        end else if (grant_data) begin
            last_fetch <= 1'b0;
        end
    end

    assign prefer_data = last_fetch;
`else
    assign prefer_data = 1'b1;
`endif

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        complete    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.d_req && (!bus.i_req || prefer_data)) begin
                    grant_data = 1'b1;
                    owner_next = OWN_DATA;
                    state_next = S_ADDR;
                end else if (bus.i_req) begin
                    grant_fetch = 1'b1;
                    owner_next  = OWN_FETCH;
                    state_next  = S_ADDR;
                end
            end
            S_ADDR: begin
                state_next = S_DATA;
            end
            S_DATA: begin
                if (!bus.mem_wait) begin
                    complete = 1'b1;
                    // A held lock skips arbitration entirely, so fetch cannot slip into a swap.
                    if ((owner == OWN_DATA) && bus.d_lock && bus.d_req) begin
                        grant_data = 1'b1;
                        state_next = S_ADDR;
                    end else begin
                        owner_next = OWN_NONE;
                        state_next = S_IDLE;
                    end
                end
            end
            default: begin
                owner_next = OWN_NONE;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            owner       <= OWN_NONE;
            bus.trans   <= 2'd0;
            bus.addr    <= {ADDR_W{1'b0}};
            bus.wdata   <= {DATA_W{1'b0}};
            bus.write   <= 1'b0;
            bus.size    <= 2'd0;
            bus.prot    <= 4'd0;
            bus.i_done  <= 1'b0;
            bus.d_done  <= 1'b0;
            bus.i_rdata <= {DATA_W{1'b0}};
            bus.d_rdata <= {DATA_W{1'b0}};
            bus.i_abort <= 1'b0;
            bus.d_abort <= 1'b0;
        end else begin
            state     <= state_next;
            owner     <= owner_next;
            bus.trans <= (grant_data || grant_fetch) ? 2'd2 : 2'd0;
            if (grant_data) begin
                bus.addr  <= bus.d_addr;
                bus.wdata <= bus.d_wdata;
                bus.write <= bus.d_write;
                bus.size  <= bus.d_size;
                bus.prot  <= bus.d_prot;
            end else if (grant_fetch) begin
                bus.addr  <= bus.i_addr;
                bus.wdata <= {DATA_W{1'b0}};
                bus.write <= 1'b0;
                bus.size  <= 2'd2;
                bus.prot  <= bus.i_prot;
            end
            bus.i_done <= complete && (owner == OWN_FETCH);
            bus.d_done <= complete && (owner == OWN_DATA);
            if (complete && (owner == OWN_FETCH)) begin
                bus.i_rdata <= bus.rdata;
                bus.i_abort <= bus.abort;
            end
            if (complete && (owner == OWN_DATA)) begin
                bus.d_rdata <= bus.rdata;
                bus.d_abort <= bus.abort;
            end
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter
module tb_memory_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          abort;
    } exp_t;

    typedef struct {
        bit          port;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          write;
        logic [1:0]  size;
        logic [3:0]  prot;
        int          wait_n;
        bit          abort;
        logic [31:0] exp_wdata;
        bit          exp_write;
        logic [1:0]  exp_size;
        int          exp_done_cyc;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[6];
    int          resp_wait  = 0;
    bit          resp_abort = 1'b0;
    logic [31:0] li_rdata, ld_rdata;
    bit          li_abort, ld_abort;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hE3A00001;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event within budget expected event", name);
    endtask

    // Memory model: responds to each address phase, stretches the data phase by resp_wait cycles.
    initial begin
        int k;
        bit in_data;
        k = 0;
        in_data = 1'b0;
        bus.rdata = '0;
        bus.abort = 1'b0;
        bus.mem_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.trans == 2'd2) begin
                in_data = 1'b1;
                k = 0;
                bus.mem_wait = 1'b0;
                bus.rdata = mem_word(bus.addr);
                bus.abort = resp_abort;
            end else if (in_data) begin
                k++;
                bus.mem_wait = (k <= resp_wait);
                if (!bus.mem_wait) in_data = 1'b0;
            end
        end
    end

    // Scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.i_done && bus.d_done) begin
                checks++;
                errors++;
                $display("FAIL both_done: got i_done=1 d_done=1 expected at most one");
            end else if (bus.i_done || bus.d_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got done (d_done=%0b) expected none", bus.d_done);
                end else begin
                    e = sb.pop_front();
                    check("sb_port", 64'(bus.d_done), 64'(e.port));
                    check("sb_rdata", 64'(bus.d_done ? bus.d_rdata : bus.i_rdata), 64'(e.rdata));
                    check("sb_abort", 64'(bus.d_done ? bus.d_abort : bus.i_abort), 64'(e.abort));
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.i_req = 1'b0; bus.i_addr = '0; bus.i_prot = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_write = 1'b0;
        bus.d_size = '0; bus.d_prot = '0; bus.d_lock = 1'b0;
    endtask

    task automatic check_reset_state(input string p);
        check({p, "_trans"}, 64'(bus.trans), 0);
        check({p, "_addr"}, 64'(bus.addr), 0);
        check({p, "_wdata"}, 64'(bus.wdata), 0);
        check({p, "_write"}, 64'(bus.write), 0);
        check({p, "_size"}, 64'(bus.size), 0);
        check({p, "_prot"}, 64'(bus.prot), 0);
        check({p, "_i_done"}, 64'(bus.i_done), 0);
        check({p, "_d_done"}, 64'(bus.d_done), 0);
        check({p, "_i_rdata"}, 64'(bus.i_rdata), 0);
        check({p, "_d_rdata"}, 64'(bus.d_rdata), 0);
        check({p, "_i_abort"}, 64'(bus.i_abort), 0);
        check({p, "_d_abort"}, 64'(bus.d_abort), 0);
        li_rdata = '0; ld_rdata = '0; li_abort = 1'b0; ld_abort = 1'b0;
    endtask

    // which: 0 = address phase, 1 = i_done, 2 = d_done
    task automatic wait_ev(input string tag, input int which, input int budget, output int cyc, output bit hit);
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < budget) begin
            @(negedge clk);
            cyc++;
            case (which)
                0:       hit = (bus.trans == 2'd2);
                1:       hit = bus.i_done;
                default: hit = bus.d_done;
            endcase
        end
        if (!hit) timeout_fail(tag);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        bit seen_addr, done;
        @(negedge clk);
        resp_wait  = v.wait_n;
        resp_abort = v.abort;
        bus.d_wdata = v.wdata; bus.d_write = v.write; bus.d_size = v.size; bus.d_lock = 1'b0;
        if (v.port) begin
            bus.d_req = 1'b1; bus.d_addr = v.addr; bus.d_prot = v.prot;
            bus.i_req = 1'b0; bus.i_addr = 32'hFFFF_FFF0; bus.i_prot = ~v.prot;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = v.addr; bus.i_prot = v.prot;
            bus.d_req = 1'b0; bus.d_addr = 32'hBAD0_0000; bus.d_prot = ~v.prot;
        end
        sb.push_back('{v.port, mem_word(v.addr), v.abort});
        cyc = 0; seen_addr = 1'b0; done = 1'b0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.trans == 2'd2 && !seen_addr) begin
                seen_addr = 1'b1;
                check({tag, "_grant_cyc"}, 64'(cyc), 1);
                check({tag, "_addr"}, 64'(bus.addr), 64'(v.addr));
                check({tag, "_wdata"}, 64'(bus.wdata), 64'(v.exp_wdata));
                check({tag, "_write"}, 64'(bus.write), 64'(v.exp_write));
                check({tag, "_size"}, 64'(bus.size), 64'(v.exp_size));
                check({tag, "_prot"}, 64'(bus.prot), 64'(v.prot));
            end
            if (v.port ? bus.d_done : bus.i_done) done = 1'b1;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        if (!seen_addr) timeout_fail({tag, "_grant"});
        if (!done) begin
            timeout_fail({tag, "_done"});
        end else begin
            check({tag, "_done_cyc"}, 64'(cyc), 64'(v.exp_done_cyc));
            if (v.port) begin
                check({tag, "_hold_i_rdata"}, 64'(bus.i_rdata), 64'(li_rdata));
                check({tag, "_hold_i_abort"}, 64'(bus.i_abort), 64'(li_abort));
                ld_rdata = mem_word(v.addr); ld_abort = v.abort;
            end else begin
                check({tag, "_hold_d_rdata"}, 64'(bus.d_rdata), 64'(ld_rdata));
                check({tag, "_hold_d_abort"}, 64'(bus.d_abort), 64'(ld_abort));
                li_rdata = mem_word(v.addr); li_abort = v.abort;
            end
        end
        @(negedge clk);
        check({tag, "_done_width"}, 64'(v.port ? bus.d_done : bus.i_done), 0);
        check({tag, "_idle"}, 64'(bus.trans), 0);
    endtask

    initial begin
        int  cyc, ndone;
        bit  hit;
        bit  ord[4];

        //          port addr          wdata         wr size  prot wait ab  exp_wdata     ewr esz  edone
        vecs[0] = '{1'b0, 32'h100, 32'hFFFF_FFFF, 1'b1, 2'd1, 4'h2, 0, 1'b0, 32'h0,         1'b0, 2'd2, 3};
        vecs[1] = '{1'b1, 32'h200, 32'hDEAD_BEEF, 1'b1, 2'd0, 4'h1, 3, 1'b0, 32'hDEAD_BEEF, 1'b1, 2'd0, 6};
        vecs[2] = '{1'b1, 32'h204, 32'h0,         1'b0, 2'd2, 4'h3, 1, 1'b0, 32'h0,         1'b0, 2'd2, 4};
        vecs[3] = '{1'b0, 32'h108, 32'h1111_2222, 1'b1, 2'd0, 4'hA, 0, 1'b1, 32'h0,         1'b0, 2'd2, 3};
        vecs[4] = '{1'b1, 32'h20A, 32'h0000_CAFE, 1'b1, 2'd1, 4'h1, 0, 1'b1, 32'h0000_CAFE, 1'b1, 2'd1, 3};
        vecs[5] = '{1'b0, 32'h10C, 32'h0,         1'b0, 2'd0, 4'h2, 2, 1'b0, 32'h0,         1'b0, 2'd2, 5};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state("rst");

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Both ports held for four transactions.
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        ord[0] = 1'b1; ord[1] = 1'b0; ord[2] = 1'b1; ord[3] = 1'b0;
`else
        ord[0] = 1'b1; ord[1] = 1'b1; ord[2] = 1'b1; ord[3] = 1'b1;
`endif
        @(negedge clk);
        resp_wait = 0; resp_abort = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h140; bus.i_prot = 4'h4;
        bus.d_req = 1'b1; bus.d_addr = 32'h240; bus.d_write = 1'b0; bus.d_size = 2'd2;
        bus.d_prot = 4'h3; bus.d_lock = 1'b0;
        for (int k = 0; k < 4; k++) sb.push_back('{ord[k], mem_word(ord[k] ? 32'h240 : 32'h140), 1'b0});
        ndone = 0; cyc = 0;
        while (ndone < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.i_done || bus.d_done) ndone++;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        check("arb_done_count", 64'(ndone), 4);
        check("arb_cycles", 64'(cyc), 12);
        repeat (2) @(negedge clk);
        check("arb_idle", 64'(bus.trans), 0);

        // Locked swap with fetch pending throughout.
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h180; bus.i_prot = 4'h6;
        bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_write = 1'b0; bus.d_wdata = '0;
        bus.d_size = 2'd2; bus.d_prot = 4'h5; bus.d_lock = 1'b1;
        sb.push_back('{1'b1, mem_word(32'h300), 1'b0});
        sb.push_back('{1'b1, mem_word(32'h300), 1'b0});
        sb.push_back('{1'b0, mem_word(32'h180), 1'b0});
        wait_ev("swap_grant", 0, 10, cyc, hit);
        check("swap_load_write", 64'(bus.write), 0);
        bus.d_write = 1'b1; bus.d_wdata = 32'h1234_5678;
        wait_ev("swap_first_done", 2, 20, cyc, hit);
        check("swap_no_idle", 64'(bus.trans), 2);
        check("swap_store_addr", 64'(bus.addr), 64'(32'h300));
        check("swap_store_write", 64'(bus.write), 1);
        check("swap_store_wdata", 64'(bus.wdata), 64'(32'h1234_5678));
        bus.d_lock = 1'b0;
        wait_ev("swap_second_done", 2, 20, cyc, hit);
        check("swap_lock_cycles", 64'(cyc), 2);
        bus.d_req = 1'b0;
        wait_ev("swap_fetch_done", 1, 20, cyc, hit);
        check("swap_fetch_cyc", 64'(cyc), 3);
        bus.i_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during a stretched data phase discards the transaction.
        resp_wait = 5; resp_abort = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h400; bus.d_write = 1'b0; bus.d_size = 2'd2;
        bus.d_prot = 4'h0; bus.d_lock = 1'b0;
        wait_ev("midrst_grant", 0, 10, cyc, hit);
        @(negedge clk);
        reset = 1'b1;
        bus.d_req = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        run_vec(vecs[0], "post_rst");

        check("sb_empty", 64'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter that shares the single memory_controller bus between the processor's instruction-fetch port and its data (load/store/swap) port. Accepts independent request/attribute bundles, selects one owner per transaction, drives the memory_controller address-phase signals (addr, wdata, write, size, prot, trans), and returns rdata/abort to the winning port with a one-cycle done pulse. Sits between the processor core and memory_controller.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- i_req  input  1  fetch request, held until i_done
- i_addr  input  ADDR_W  fetch address
- i_prot  input  4  fetch protection attributes
- i_done  output  1  one-cycle pulse: fetch transaction complete
- i_rdata  output  DATA_W  fetch read data, valid with i_done
- i_abort  output  1  fetch abort, valid with i_done
- d_req  input  1  data request, held until d_done
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_write  input  1  1 = store, 0 = load
- d_size  input  2  0 = byte, 1 = half, 2 = word
- d_prot  input  4  data protection attributes
- d_lock  input  1  locked sequence (swap): keep ownership for next data transaction
- d_done  output  1  one-cycle pulse: data transaction complete
- d_rdata  output  DATA_W  data read data, valid with d_done
- d_abort  output  1  data abort, valid with d_done
- addr  output  ADDR_W  to memory_controller
- wdata  output  DATA_W  to memory_controller
- write  output  1  to memory_controller
- size  output  2  to memory_controller
- prot  output  4  to memory_controller
- trans  output  2  0 = idle, 2 = non-sequential
- rdata  input  DATA_W  from memory_controller
- abort  input  1  from memory_controller
- mem_wait  input  1  memory extends data phase while high

## Operation
- States: IDLE, ADDR, DATA. Owner register: NONE/FETCH/DATA.
- IDLE: if any request, choose owner (see arbitration), latch owner's attributes into output registers, trans=2, go ADDR. Else trans=0.
- ADDR: one cycle of address phase; next state DATA; trans returns to 0 on entry to DATA.
- DATA: while mem_wait=1 stay. When mem_wait=0: capture rdata/abort into owner's i_/d_ rdata/abort, pulse owner's done for one cycle.
  - If owner=DATA and d_lock=1 and d_req=1: go directly to ADDR with new data attributes (no arbitration; fetch blocked).
  - Else go IDLE; owner=NONE.
- Fetch attributes: write=0, size=2, wdata=0.
- Non-owner's done is 0; non-owner's rdata/abort hold previous values.
- Arbitration (default): data port has fixed priority over fetch.
- Requester must keep req and attributes stable until its done; arbiter samples attributes only on grant. A req deasserted before grant is ignored without error.
- Abort is passed through, not retried; lock chain continues only if requester keeps d_req.
- Reset: state=IDLE, owner=NONE, trans=0, addr=0, wdata=0, write=0, size=0, prot=0, both done=0, both rdata=0, both abort=0; in-flight transaction discarded with no done. Round-robin pointer resets to "last=fetch".

## Timing
- Request seen at edge N (IDLE) -> address phase cycles N+1; done pulse at N+2 with zero wait states; each mem_wait cycle adds one.
- Minimum 3 cycles between successive unlocked grants (IDLE, ADDR, DATA); locked continuation: 2 cycles (ADDR, DATA).
- done, rdata, abort registered; done is high exactly one cycle per transaction.
- Requester may deassert req in cycle after done; a req still high in that cycle is treated as a new request.

## Configuration
- MEMORY_ARBITER_ROUND_ROBIN_EN defined: when both request in IDLE, grant the port not granted last; pointer updates on each grant (locked continuations count as data grants).
- Undefined: fixed data-over-fetch priority; no pointer register.

## Test plan
- Lone fetch, i_addr=0x100, rdata=0xE3A00001, mem_wait=0 -> trans=2/addr=0x100 one cycle, i_done at +2 cycles with i_rdata=0xE3A00001, write=0, size=2.
- Lone store d_addr=0x200, d_wdata=0xDEADBEEF, size=0, mem_wait high 3 cycles -> write=1, size=0; d_done exactly 5 cycles after request, single pulse.
- Simultaneous i_req and d_req held for 4 transactions -> default: data, data... fetch starved while d_req high; with ROUND_ROBIN_EN: data, fetch, data, fetch.
- Swap: d_lock=1 load 0x300 then store 0x300 with i_req high throughout -> two back-to-back data transactions, no fetch between, second starts with no IDLE cycle.
- abort=1 on fetch data phase -> i_abort=1 with i_done, d_abort unchanged, arbiter returns IDLE.
- reset asserted during DATA with mem_wait=1 -> next cycle trans=0, no done pulse, all outputs at reset values; new request after reset served normally.
